// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings and bridge state type.
package axi3_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [2:0] {
    IDLE,
    RDREQ,
    RDRESP,
    WRDATA,
    WRREQ,
    WRRESP
  } state_e;

  // Response codes are ordered by severity, so the worse one is the larger.
  function automatic resp_e resp_merge(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi3_addrgen.sv
// Combinational AXI3 beat address generator: next address, bus-aligned
// address and illegal-burst detection.
module axi3_addrgen
  import axi3_pkg::*;
#(
  parameter int unsigned ADDR = 32,
  parameter int unsigned DATA = 32
) (
  input  logic [ADDR-1:0] i_addr,
  input  logic [2:0]      i_size,
  input  logic [3:0]      i_len,
  input  logic [1:0]      i_burst,
  output logic [ADDR-1:0] o_next_addr,
  output logic [ADDR-1:0] o_aligned_addr,
  output logic            o_illegal
);

  localparam int unsigned LG = $clog2(DATA / 8);

  logic [ADDR-1:0] w_incr;
  logic [ADDR-1:0] w_mask;
  logic [ADDR-1:0] w_sum;

  always_comb begin
    w_incr         = ADDR'(1) << i_size;
    // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size.
    w_mask         = ((ADDR'(i_len) + ADDR'(1)) << i_size) - ADDR'(1);
    w_sum          = i_addr + w_incr;
    o_aligned_addr = {i_addr[ADDR-1:LG], LG'(0)};
    case (i_burst)
      FIXED:   o_next_addr = i_addr;
      INCR:    o_next_addr = w_sum;
      WRAP:    o_next_addr = (i_addr & ~w_mask) | (w_sum & w_mask);
      default: o_next_addr = i_addr;
    endcase
    o_illegal = (i_burst == 2'b11) || (i_size > 3'(LG)) ||
                ((i_burst == WRAP) && !(i_len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  end

endmodule

// File: rtl/axi3_slave_bridge.sv
// AXI3 slave to simple request/ack downstream bridge; one transaction at a
// time, per-beat downstream access with timeout.
module axi3_slave_bridge
  import axi3_pkg::*;
#(
  parameter int unsigned ADDR     = 32,
  parameter int unsigned DATA     = 32,
  parameter int unsigned ID       = 12,
  parameter int unsigned TIMEBITS = 8,
  parameter int unsigned TIMEOUT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID-1:0]     awid,
  input  logic [ADDR-1:0]   awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic [3:0]        awqos,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ID-1:0]     wid,
  input  logic [DATA-1:0]   wdata,
  input  logic [DATA/8-1:0] wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID-1:0]     bid,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID-1:0]     arid,
  input  logic [ADDR-1:0]   araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic [3:0]        arqos,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID-1:0]     rid,
  output logic [DATA-1:0]   rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              outreq,
  output logic              outwr,
  output logic [ADDR-1:0]   outaddr,
  output logic [DATA-1:0]   outwdata,
  output logic [DATA/8-1:0] outwstrb,
  input  logic              outack,
  input  logic              outerr,
  input  logic [DATA-1:0]   outrdata
);

  localparam int unsigned       STRB  = DATA / 8;
  localparam logic [TIMEBITS-1:0] TLOAD = TIMEBITS'(TIMEOUT);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ID-1:0]       r_id;
  logic [ADDR-1:0]     r_addr;
  logic [3:0]          r_len;
  logic [3:0]          r_beat;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_favour_rd;
  logic [TIMEBITS-1:0] r_timer;
  logic [DATA-1:0]     r_rdata;
  logic [DATA-1:0]     r_wdata;
  logic [STRB-1:0]     r_wstrb;
  resp_e               r_rresp;
  resp_e               r_bresp;

  logic [ADDR-1:0] w_next_addr;
  logic [ADDR-1:0] w_aligned_addr;
  logic            w_illegal;
  logic            w_last;
  logic            w_timeout;
  logic            w_grant_wr;
  logic            w_grant_rd;
  logic            w_rd_capture;
  logic            w_wr_accept;
  logic            w_wr_done;
  logic            w_advance;
  logic            w_reload;
  logic            w_unused;

  assign w_unused = &{1'b0, awlock, awcache, awprot, awqos,
                      arlock, arcache, arprot, arqos, wid};

  axi3_addrgen #(.ADDR(ADDR), .DATA(DATA)) u_addrgen (
    .i_addr         (r_addr),
    .i_size         (r_size),
    .i_len          (r_len),
    .i_burst        (r_burst),
    .o_next_addr    (w_next_addr),
    .o_aligned_addr (w_aligned_addr),
    .o_illegal      (w_illegal)
  );

  assign w_last    = (r_beat == r_len);
  assign w_timeout = (TIMEOUT != 0) && (r_timer == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_wr   = 1'b0;
    w_grant_rd   = 1'b0;
    w_rd_capture = 1'b0;
    w_wr_accept  = 1'b0;
    w_wr_done    = 1'b0;
    w_advance    = 1'b0;
    w_reload     = 1'b0;
    case (r_state)
      IDLE: begin
        if (awvalid && (!arvalid || !r_favour_rd)) begin
          w_grant_wr  = 1'b1;
          w_state_nxt = WRDATA;
        end else if (arvalid) begin
          w_grant_rd  = 1'b1;
          w_state_nxt = RDREQ;
        end
      end
      RDREQ: begin
        if (w_illegal || outack || w_timeout) begin
          w_rd_capture = 1'b1;
          w_state_nxt  = RDRESP;
        end
      end
      RDRESP: begin
        if (rready) begin
          if (w_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_advance   = 1'b1;
            w_reload    = 1'b1;
            w_state_nxt = RDREQ;
          end
        end
      end
      WRDATA: begin
        if (wvalid) begin
          w_wr_accept = 1'b1;
          // Illegal bursts and empty strobes consume the beat without access.
          if (w_illegal || (wstrb == '0)) begin
            w_advance   = 1'b1;
            w_state_nxt = w_last ? WRRESP : WRDATA;
          end else begin
            w_reload    = 1'b1;
            w_state_nxt = WRREQ;
          end
        end
      end
      WRREQ: begin
        if (outack || w_timeout) begin
          w_wr_done   = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = w_last ? WRRESP : WRDATA;
        end
      end
      WRRESP: begin
        if (bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_beat      <= '0;
      r_timer     <= '0;
      r_favour_rd <= 1'b1;
      r_rdata     <= '0;
      r_rresp     <= OKAY;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bresp     <= OKAY;
    end else begin
      if (w_grant_wr) begin
        r_id        <= awid;
        r_addr      <= awaddr;
        r_len       <= awlen;
        r_size      <= awsize;
        r_burst     <= awburst;
        r_beat      <= '0;
        r_bresp     <= OKAY;
        r_favour_rd <= 1'b1;
      end else if (w_grant_rd) begin
        r_id        <= arid;
        r_addr      <= araddr;
        r_len       <= arlen;
        r_size      <= arsize;
        r_burst     <= arburst;
        r_beat      <= '0;
        r_favour_rd <= 1'b0;
      end
      if (w_advance) begin
        r_addr <= w_next_addr;
        r_beat <= r_beat + 4'd1;
      end
      if (w_grant_wr || w_grant_rd || w_reload) begin
        r_timer <= TLOAD;
      end else if (((r_state == RDREQ) || (r_state == WRREQ)) && (r_timer != '0)) begin
        r_timer <= r_timer - TIMEBITS'(1);
      end
      // An ack arriving on the last timer cycle still counts as a response.
      if (w_rd_capture) begin
        r_rdata <= outrdata;
        r_rresp <= w_illegal ? SLVERR : (outack ? (outerr ? SLVERR : OKAY) : DECERR);
      end
      if (w_wr_accept) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
        if (w_illegal || (wlast != w_last)) r_bresp <= resp_merge(r_bresp, SLVERR);
      end
      if (w_wr_done) begin
        r_bresp <= resp_merge(r_bresp, outack ? (outerr ? SLVERR : OKAY) : DECERR);
      end
    end
  end

  assign awready  = w_grant_wr;
  assign arready  = w_grant_rd;
  assign wready   = (r_state == WRDATA);
  assign rvalid   = (r_state == RDRESP);
  assign bvalid   = (r_state == WRRESP);
  assign outreq   = ((r_state == RDREQ) && !w_illegal) || (r_state == WRREQ);
  assign outwr    = (r_state == WRREQ);
  assign outaddr  = w_aligned_addr;
  assign outwdata = r_wdata;
  assign outwstrb = r_wstrb;
  assign rid      = r_id;
  assign bid      = r_id;
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;
  assign bresp    = r_bresp;
  assign rlast    = rvalid && w_last;

endmodule

// File: tb/tb_axi3_slave_bridge.sv
// Directed self-checking bench for axi3_slave_bridge with a simple
// acknowledging downstream responder.
module tb_axi3_slave_bridge;
  import axi3_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [11:0] awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, outaddr, outwdata, outrdata;
  logic [3:0]  awlen, arlen, awcache, arcache, awqos, arqos, wstrb, outwstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        outreq, outwr, outack, outerr;

  axi3_slave_bridge #(.ADDR(32), .DATA(32), .ID(12), .TIMEBITS(8), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .outreq(outreq), .outwr(outwr), .outaddr(outaddr), .outwdata(outwdata),
    .outwstrb(outwstrb), .outack(outack), .outerr(outerr), .outrdata(outrdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rq_resp[$];
  logic        rq_last[$];
  logic [31:0] rq_data[$];
  logic [11:0] rq_id[$];
  int          rq_cyc[$];
  logic [1:0]  b_resp[$];
  logic [11:0] b_id[$];
  logic [31:0] ds_addr[$];
  logic [31:0] ds_wdata[$];
  logic        ds_wr[$];
  int          ack_cnt = 0;
  int          req_cycles = 0;
  int          err_at = -1;
  logic        ack_en = 1'b1;

  // Response logging and single-pulse downstream acknowledge.
  always @(negedge clk) begin
    if (rvalid && rready) begin
      rq_resp.push_back(rresp);
      rq_last.push_back(rlast);
      rq_data.push_back(rdata);
      rq_id.push_back(rid);
      rq_cyc.push_back(cyc);
    end
    if (bvalid && bready) begin
      b_resp.push_back(bresp);
      b_id.push_back(bid);
    end
    if (outreq) req_cycles++;
    if (outreq && ack_en && !outack) begin
      outack   = 1'b1;
      outerr   = (ack_cnt == err_at);
      outrdata = 32'hA500_0000 ^ outaddr;
      ds_addr.push_back(outaddr);
      ds_wr.push_back(outwr);
      ds_wdata.push_back(outwdata);
      ack_cnt++;
    end else begin
      outack = 1'b0;
      outerr = 1'b0;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic aw_send(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic hs;
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    hs = 1'b0;
    for (int n = 0; n < 100 && !hs; n++) begin
      #1 hs = awready;
      @(negedge clk);
    end
    awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'(1));
  endtask

  task automatic ar_send(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic hs;
    @(negedge clk);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    hs = 1'b0;
    for (int n = 0; n < 100 && !hs; n++) begin
      #1 hs = arready;
      @(negedge clk);
    end
    arvalid = 1'b0;
    check("ar_handshake", 64'(hs), 64'(1));
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    logic hs;
    @(negedge clk);
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
    hs = 1'b0;
    for (int n = 0; n < 100 && !hs; n++) begin
      #1 hs = wready;
      @(negedge clk);
    end
    wvalid = 1'b0;
    check("w_handshake", 64'(hs), 64'(1));
  endtask

  task automatic wait_rq(input int n);
    for (int k = 0; k < 300 && rq_resp.size() < n; k++) @(negedge clk);
    #1;
    check("r_beat_count", 64'(rq_resp.size()), 64'(n));
  endtask

  task automatic wait_b(input int n);
    for (int k = 0; k < 300 && b_resp.size() < n; k++) @(negedge clk);
    #1;
    check("b_count", 64'(b_resp.size()), 64'(n));
  endtask

  initial begin
    int s0, r0, b0, t0, req0;
    logic got;
    logic [31:0] wrap_exp [4];
    wrap_exp = '{32'h38, 32'h3C, 32'h30, 32'h34};
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    awlock = 0; awcache = 0; awprot = 0; awqos = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    arlock = 0; arcache = 0; arprot = 0; arqos = 0;
    wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0;
    rready = 1; bready = 1;
    outack = 0; outerr = 0; outrdata = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl", 64'({awready, arready, wready, rvalid, bvalid, outreq, outwr, rlast}), 64'(0));
    check("rst_resp", 64'({rresp, bresp}), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_ids", 64'({rid, bid}), 64'(0));
    @(negedge clk) reset = 1'b0;

    // Simultaneous requests: read wins after reset, write wins next.
    @(negedge clk);
    awvalid = 1; awid = 12'h7; awaddr = 32'h300; awlen = 0; awsize = 2; awburst = INCR;
    arvalid = 1; arid = 12'h5; araddr = 32'h200; arlen = 0; arsize = 2; arburst = INCR;
    b0 = b_resp.size();
    #1;
    check("arb1_ready", 64'({arready, awready}), 64'(2'b10));
    @(negedge clk);
    arvalid = 0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      #1 got = rvalid;
    end
    check("arb1_rvalid", 64'(got), 64'(1));
    check("arb1_rid", 64'(rid), 64'(12'h5));
    @(negedge clk);
    arvalid = 1;
    #1;
    check("arb2_ready", 64'({arready, awready}), 64'(2'b01));
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    w_send(32'hCAFE_0001, 4'hF, 1'b1);
    wait_b(b0 + 1);
    check("arb2_bresp", 64'(b_resp[b0]), 64'(OKAY));
    check("arb2_bid", 64'(b_id[b0]), 64'(12'h7));

    // INCR read, 4 beats of 4 bytes from 0x100.
    s0 = ds_addr.size(); r0 = rq_resp.size();
    ar_send(12'h3, 32'h100, 4'd3, 3'd2, INCR);
    wait_rq(r0 + 4);
    check("incr_ds_count", 64'(ds_addr.size()), 64'(s0 + 4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_addr%0d", i), 64'(ds_addr[s0+i]), 64'(32'h100 + 4 * i));
      check($sformatf("incr_outwr%0d", i), 64'(ds_wr[s0+i]), 64'(0));
      check($sformatf("incr_rlast%0d", i), 64'(rq_last[r0+i]), 64'(i == 3));
      check($sformatf("incr_rresp%0d", i), 64'(rq_resp[r0+i]), 64'(OKAY));
    end
    check("incr_rdata0", 64'(rq_data[r0]), 64'(32'hA500_0100));
    check("incr_rdata3", 64'(rq_data[r0+3]), 64'(32'hA500_010C));
    check("incr_rid", 64'(rq_id[r0+3]), 64'(12'h3));

    // WRAP write, 4 beats of 4 bytes starting at 0x38.
    s0 = ds_addr.size(); b0 = b_resp.size();
    aw_send(12'h2A, 32'h38, 4'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) w_send(32'h1000 + i, 4'hF, 1'(i == 3));
    wait_b(b0 + 1);
    check("wrap_ds_count", 64'(ds_addr.size()), 64'(s0 + 4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_addr%0d", i), 64'(ds_addr[s0+i]), 64'(wrap_exp[i]));
      check($sformatf("wrap_outwr%0d", i), 64'(ds_wr[s0+i]), 64'(1));
    end
    check("wrap_wdata2", 64'(ds_wdata[s0+2]), 64'(32'h1002));
    check("wrap_bresp", 64'(b_resp[b0]), 64'(OKAY));
    check("wrap_bid", 64'(b_id[b0]), 64'(12'h2A));

    // 2-beat read with no downstream ack: DECERR 11 cycles after each RDREQ entry.
    ack_en = 1'b0;
    s0 = ds_addr.size(); r0 = rq_resp.size();
    ar_send(12'h8, 32'h700, 4'd1, 3'd2, INCR);
    t0 = cyc;
    wait_rq(r0 + 2);
    check("tmo_resp0", 64'(rq_resp[r0]), 64'(DECERR));
    check("tmo_resp1", 64'(rq_resp[r0+1]), 64'(DECERR));
    check("tmo_lat0", 64'(rq_cyc[r0] - t0), 64'(11));
    check("tmo_lat1", 64'(rq_cyc[r0+1] - rq_cyc[r0] - 1), 64'(11));
    check("tmo_rlast1", 64'(rq_last[r0+1]), 64'(1));
    check("tmo_no_ds", 64'(ds_addr.size()), 64'(s0));
    ack_en = 1'b1;

    // 3-beat write: outerr on beat 2, empty strobe on beat 3.
    s0 = ds_addr.size(); b0 = b_resp.size();
    err_at = ack_cnt + 1;
    aw_send(12'h9, 32'h400, 4'd2, 3'd2, INCR);
    w_send(32'h0000_0001, 4'hF, 1'b0);
    w_send(32'h0000_0002, 4'hF, 1'b0);
    w_send(32'h0000_0003, 4'h0, 1'b1);
    wait_b(b0 + 1);
    err_at = -1;
    check("err_ds_count", 64'(ds_addr.size()), 64'(s0 + 2));
    check("err_addr1", 64'(ds_addr[s0+1]), 64'(32'h404));
    check("err_bresp", 64'(b_resp[b0]), 64'(SLVERR));

    // Oversized beat on a 32-bit bus: no downstream access, SLVERR.
    s0 = ds_addr.size(); b0 = b_resp.size(); req0 = req_cycles;
    aw_send(12'h4, 32'h500, 4'd0, 3'd3, INCR);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_b(b0 + 1);
    check("size3_no_req", 64'(req_cycles), 64'(req0));
    check("size3_bresp", 64'(b_resp[b0]), 64'(SLVERR));

    // Reset while RDREQ is waiting on the downstream side.
    ack_en = 1'b0;
    ar_send(12'h6, 32'h600, 4'd0, 3'd2, INCR);
    @(negedge clk);
    #1;
    check("rdreq_outreq", 64'(outreq), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_outreq", 64'(outreq), 64'(0));
    r0 = rq_resp.size(); req0 = req_cycles;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("rst_mid_no_rvalid", 64'(rq_resp.size()), 64'(r0));
    check("rst_mid_no_req", 64'(req_cycles), 64'(req0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
